// File: rtl/spi_flash_loader.sv
// rtl/spi_flash_loader.sv - boot-copy engine: chunked SPI READ from flash through spi_mst into byte memory
module spi_flash_loader #(
    parameter int FIFO_DEPTH = 16,
    parameter int CHUNK      = 12,
    parameter int ADDR_W     = 16,
    parameter int CLK_DIV    = 4
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic              start_i,
    input  logic [23:0]       flash_addr_i,
    input  logic [ADDR_W-1:0] mem_addr_i,
    input  logic [ADDR_W:0]   len_i,
    output logic              busy_o,
    output logic              done_o,
    output logic              hs_read_o,
    output logic              hs_write_o,
    output logic [4:0]        hs_addr_o,
    output logic [7:0]        hs_data_o,
    input  logic              hs_ready_i,
    input  logic [7:0]        hs_data_i,
    output logic              mem_we_o,
    output logic [ADDR_W-1:0] mem_addr_o,
    output logic [7:0]        mem_wdata_o,
    input  logic              mem_ready_i
);
    localparam int          CW     = $clog2(FIFO_DEPTH + 1);
    localparam logic [15:0] DIV    = 16'(CLK_DIV);
    localparam logic [4:0]  A_CTRL = 5'h00;
    localparam logic [4:0]  A_TX   = 5'h08;
    localparam logic [4:0]  A_RX   = 5'h0C;
    localparam logic [4:0]  A_LVL  = 5'h14;
    localparam logic [4:0]  A_DLO  = 5'h18;
    localparam logic [4:0]  A_DHI  = 5'h1C;

    typedef enum logic [3:0] {
        S_IDLE, S_CFG_DL, S_CFG_DH, S_INHIBIT, S_PUSH_HDR, S_PUSH_FILL,
        S_RELEASE, S_POLL, S_DISCARD, S_POP_DATA, S_NEXT, S_FINISH
    } state_t;

    state_t            state, state_nx;
    logic [23:0]       fa;
    logic [ADDR_W-1:0] ma;
    logic [ADDR_W:0]   remaining;
    logic [CW-1:0]     n, cnt, n_calc;
    logic              gap;
    logic [7:0]        hdr_byte;

    assign n_calc = (remaining < (ADDR_W+1)'(CHUNK)) ? CW'(remaining) : CW'(CHUNK);

    always_comb begin
        hdr_byte = fa[7:0];
        case (cnt[1:0])
            2'd0:    hdr_byte = 8'h03;
            2'd1:    hdr_byte = fa[23:16];
            2'd2:    hdr_byte = fa[15:8];
            default: hdr_byte = fa[7:0];
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) state <= S_IDLE;
        else       state <= state_nx;
    end

    always_comb begin
        state_nx   = state;
        hs_read_o  = 1'b0;
        hs_write_o = 1'b0;
        hs_addr_o  = A_CTRL;
        hs_data_o  = 8'h00;
        busy_o     = (state != S_IDLE) && (state != S_FINISH);
        done_o     = (state == S_FINISH);
        case (state)
            S_IDLE: if (start_i) state_nx = (len_i == '0) ? S_FINISH : S_CFG_DL;
            S_CFG_DL: begin
                hs_write_o = 1'b1;
                hs_addr_o  = A_DLO;
                hs_data_o  = DIV[7:0];
                if (hs_ready_i) state_nx = S_CFG_DH;
            end
            S_CFG_DH: begin
                hs_write_o = 1'b1;
                hs_addr_o  = A_DHI;
                hs_data_o  = DIV[15:8];
                if (hs_ready_i) state_nx = S_INHIBIT;
            end
            S_INHIBIT: begin
                hs_write_o = 1'b1;
                hs_data_o  = 8'h04;
                if (hs_ready_i) state_nx = S_PUSH_HDR;
            end
            S_PUSH_HDR: begin
                hs_write_o = 1'b1;
                hs_addr_o  = A_TX;
                hs_data_o  = hdr_byte;
                if (hs_ready_i && cnt == CW'(3)) state_nx = S_PUSH_FILL;
            end
            S_PUSH_FILL: begin
                hs_write_o = 1'b1;
                hs_addr_o  = A_TX;
                if (hs_ready_i && cnt == n - CW'(1)) state_nx = S_RELEASE;
            end
            S_RELEASE: begin
                hs_write_o = 1'b1;
                if (hs_ready_i) state_nx = S_POLL;
            end
            S_POLL: begin
                hs_read_o = 1'b1;
                hs_addr_o = A_LVL;
                if (hs_ready_i && hs_data_i >= 8'(CW'(4) + n)) state_nx = S_DISCARD;
            end
            S_DISCARD: begin
                if (!gap) begin
                    hs_read_o = 1'b1;
                    hs_addr_o = A_RX;
                    if (hs_ready_i && cnt == CW'(3)) state_nx = S_POP_DATA;
                end
            end
            S_POP_DATA: begin
                // a pop waits for both the RX refresh gap and the previous byte's acceptance
                if (!gap && !mem_we_o && cnt != n) begin
                    hs_read_o = 1'b1;
                    hs_addr_o = A_RX;
                end
                if (mem_we_o && mem_ready_i && cnt == n) state_nx = S_NEXT;
            end
            S_NEXT:   state_nx = (remaining == (ADDR_W+1)'(n)) ? S_FINISH : S_INHIBIT;
            S_FINISH: state_nx = S_IDLE;
            default:  state_nx = S_IDLE;
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            fa          <= '0;
            ma          <= '0;
            remaining   <= '0;
            n           <= '0;
            cnt         <= '0;
            gap         <= 1'b0;
            mem_we_o    <= 1'b0;
            mem_addr_o  <= '0;
            mem_wdata_o <= '0;
        end else begin
            case (state)
                S_IDLE: if (start_i) begin
                    fa        <= flash_addr_i;
                    ma        <= mem_addr_i;
                    remaining <= len_i;
                end
                S_INHIBIT: if (hs_ready_i) begin
                    n   <= n_calc;
                    cnt <= '0;
                end
                S_PUSH_HDR:  if (hs_ready_i) cnt <= (cnt == CW'(3)) ? '0 : cnt + CW'(1);
                S_PUSH_FILL: if (hs_ready_i) cnt <= cnt + CW'(1);
                S_POLL: begin
                    cnt <= '0;
                    gap <= 1'b0;
                end
                S_DISCARD: begin
                    if (gap) gap <= 1'b0;
                    else if (hs_ready_i) begin
                        gap <= 1'b1;
                        cnt <= (cnt == CW'(3)) ? '0 : cnt + CW'(1);
                    end
                end
                S_POP_DATA: begin
                    if (gap) gap <= 1'b0;
                    else if (mem_we_o) begin
                        if (mem_ready_i) mem_we_o <= 1'b0;
                    end else if (cnt != n && hs_ready_i) begin
                        mem_we_o    <= 1'b1;
                        mem_addr_o  <= ma + ADDR_W'(cnt);
                        mem_wdata_o <= hs_data_i;
                        cnt         <= cnt + CW'(1);
                    end
                end
                S_NEXT: begin
                    fa        <= fa + 24'(n);
                    ma        <= ma + ADDR_W'(n);
                    remaining <= remaining - (ADDR_W+1)'(n);
                end
                default: ;
            endcase
        end
    end
endmodule

// File: tb/tb_spi_flash_loader.sv
// tb/tb_spi_flash_loader.sv - randomized bench for spi_flash_loader with spi_mst, flash and memory models
module tb_spi_flash_loader;
    localparam int CHUNK   = 12;
    localparam int ADDR_W  = 16;
    localparam int CLK_DIV = 4;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        start = 1'b0;
    logic [23:0] f_addr = '0;
    logic [15:0] m_addr = '0;
    logic [16:0] len_in = '0;
    logic        busy, done, hs_read, hs_write, hs_ready, mem_we, mem_ready;
    logic [4:0]  hs_addr;
    logic [7:0]  hs_data, hs_rdata, mem_wdata;
    logic [15:0] mem_addr;

    int n_checks = 0;
    int n_fail   = 0;

    spi_flash_loader #(.FIFO_DEPTH(16), .CHUNK(CHUNK), .ADDR_W(ADDR_W), .CLK_DIV(CLK_DIV)) dut (
        .clk_i(clk), .rst_i(rst), .start_i(start), .flash_addr_i(f_addr), .mem_addr_i(m_addr),
        .len_i(len_in), .busy_o(busy), .done_o(done), .hs_read_o(hs_read), .hs_write_o(hs_write),
        .hs_addr_o(hs_addr), .hs_data_o(hs_data), .hs_ready_i(hs_ready), .hs_data_i(hs_rdata),
        .mem_we_o(mem_we), .mem_addr_o(mem_addr), .mem_wdata_o(mem_wdata), .mem_ready_i(mem_ready)
    );

    always #5 clk = ~clk;

    // spi_mst + flash model state
    logic [7:0]  tx_q[$], rx_q[$], cur_burst[$], burst_log[$];
    int          burst_len_log[$];
    logic [7:0]  ctrl_r = '0;
    logic [15:0] div_r = '0;
    bit          burst_on = 0;
    int          shift_t = 0, burst_pos = 0;
    logic [23:0] burst_addr = '0;
    logic [7:0]  salt = '0;
    logic [7:0]  m_b, m_resp;

    // memory model state
    logic [7:0]  mem [0:65535];
    int          mem_writes = 0, activity = 0, done_cnt = 0, stall_cycles = 0;
    int          stall_at = -1, stall_left = 0;
    bit          mem_rand = 1;

    logic        prev_hs_pend = 0, prev_rd = 0, prev_wr = 0, prev_mem_pend = 0, prev_pop = 0;
    logic [4:0]  prev_addr = '0;
    logic [7:0]  prev_hdata = '0, prev_mdata = '0;
    logic [15:0] prev_maddr = '0;

    function automatic logic [7:0] flash_byte(input logic [23:0] a);
        return a[7:0] ^ (salt & (a[15:8] + a[23:16]));
    endfunction

    always @(negedge clk) begin
        if (rst) begin
            tx_q.delete(); rx_q.delete(); cur_burst.delete();
            ctrl_r = '0; burst_on = 0; stall_left = 0;
            prev_hs_pend = 0; prev_mem_pend = 0; prev_pop = 0;
            hs_ready = 0; mem_ready = 0; hs_rdata = '0;
        end else begin
            if (hs_read && hs_write) begin
                n_checks++; n_fail++;
                $display("FAIL bus_exclusive: read=1 write=1, required at most one strobe");
            end
            if (prev_hs_pend) begin
                n_checks++;
                if ({hs_read, hs_write, hs_addr, hs_data} !== {prev_rd, prev_wr, prev_addr, prev_hdata}) begin
                    n_fail++;
                    $display("FAIL hs_hold: got rd=%0b wr=%0b a=%h d=%h required rd=%0b wr=%0b a=%h d=%h",
                             hs_read, hs_write, hs_addr, hs_data, prev_rd, prev_wr, prev_addr, prev_hdata);
                end
            end
            if (prev_pop) begin
                n_checks++;
                if (hs_read && hs_addr == 5'h0C) begin
                    n_fail++;
                    $display("FAIL pop_gap: RX pop issued right after previous pop, required one idle cycle");
                end
            end
            if (mem_we && hs_read && hs_addr == 5'h0C) begin
                n_checks++; n_fail++;
                $display("FAIL pop_during_mem: RX pop while mem write at %h pending, required none", mem_addr);
            end
            if (prev_mem_pend) begin
                n_checks++;
                if ({mem_we, mem_addr, mem_wdata} !== {1'b1, prev_maddr, prev_mdata}) begin
                    n_fail++;
                    $display("FAIL mem_hold: got we=%0b a=%h d=%h required we=1 a=%h d=%h",
                             mem_we, mem_addr, mem_wdata, prev_maddr, prev_mdata);
                end
            end

            hs_ready = ($urandom_range(0, 3) != 0);
            hs_rdata = 8'($urandom);
            if (stall_at >= 0 && mem_we && mem_writes == stall_at) begin
                stall_left = 5;
                stall_at   = -1;
            end
            if (stall_left > 0) begin
                mem_ready = 1'b0;
                stall_left--;
            end else begin
                mem_ready = mem_rand ? ($urandom_range(0, 3) != 0) : 1'b1;
            end
            if (mem_we && !mem_ready) stall_cycles++;

            if (burst_on) begin
                if (shift_t > 0) shift_t--;
                else if (tx_q.size() > 0) begin
                    m_b = tx_q.pop_front();
                    cur_burst.push_back(m_b);
                    m_resp = (burst_pos < 4) ? 8'hA5 : flash_byte(burst_addr + 24'(burst_pos - 4));
                    if (burst_pos == 3) burst_addr = {cur_burst[1], cur_burst[2], cur_burst[3]};
                    rx_q.push_back(m_resp);
                    burst_pos++;
                    shift_t = 2;
                    if (rx_q.size() > 16) begin
                        n_checks++; n_fail++;
                        $display("FAIL rx_overflow: level %0d required <= 16", rx_q.size());
                    end
                    if (tx_q.size() == 0) begin
                        burst_on = 0;
                        burst_len_log.push_back(cur_burst.size());
                        foreach (cur_burst[i]) burst_log.push_back(cur_burst[i]);
                        cur_burst.delete();
                    end
                end
            end

            if (hs_write && hs_ready) begin
                case (hs_addr)
                    5'h00: begin
                        if (hs_data != 8'h00 && hs_data != 8'h04) begin
                            n_checks++; n_fail++;
                            $display("FAIL ctrl_value: got %h required 00 or 04", hs_data);
                        end
                        ctrl_r = hs_data;
                        if (!hs_data[2] && tx_q.size() > 0 && !burst_on) begin
                            burst_on = 1; burst_pos = 0; shift_t = 2;
                        end
                    end
                    5'h08: begin
                        if (!ctrl_r[2] || burst_on) begin
                            n_checks++; n_fail++;
                            $display("FAIL tx_push_live: TX push with inhibit=%0b burst=%0b, required inhibited idle",
                                     ctrl_r[2], burst_on);
                        end
                        tx_q.push_back(hs_data);
                        if (tx_q.size() > 16) begin
                            n_checks++; n_fail++;
                            $display("FAIL tx_overflow: level %0d required <= 16", tx_q.size());
                        end
                    end
                    5'h18: div_r[7:0]  = hs_data;
                    5'h1C: div_r[15:8] = hs_data;
                    default: begin
                        n_checks++; n_fail++;
                        $display("FAIL bad_write_addr: got %h required 00/08/18/1C", hs_addr);
                    end
                endcase
            end
            if (hs_read && hs_ready) begin
                if (hs_addr == 5'h0C) begin
                    if (rx_q.size() == 0) begin
                        n_checks++; n_fail++;
                        $display("FAIL rx_underflow: pop from empty RX, required level >= 1");
                    end else hs_rdata = rx_q.pop_front();
                end else if (hs_addr == 5'h14) hs_rdata = 8'(rx_q.size());
                else begin
                    n_checks++; n_fail++;
                    $display("FAIL bad_read_addr: got %h required 0C/14", hs_addr);
                end
            end
            if (mem_we && mem_ready) begin
                mem[mem_addr] = mem_wdata;
                mem_writes++;
            end
            if (hs_read || hs_write || mem_we) activity++;
            if (done) done_cnt++;

            prev_hs_pend  = (hs_read || hs_write) && !hs_ready;
            prev_rd       = hs_read;
            prev_wr       = hs_write;
            prev_addr     = hs_addr;
            prev_hdata    = hs_data;
            prev_mem_pend = mem_we && !mem_ready;
            prev_maddr    = mem_addr;
            prev_mdata    = mem_wdata;
            prev_pop      = hs_read && hs_ready && hs_addr == 5'h0C;
        end
    end

    task automatic run_copy(input logic [23:0] fa, input logic [15:0] ma, input int len,
                            input string tag, input bit poke);
        int cyc, done0, act0, nb, pos, nk, bad;
        logic [23:0] ak;
        logic [7:0]  eb;
        for (int i = 0; i < len; i++) mem[ma + 16'(i)] = ~flash_byte(fa + 24'(i));
        done0 = done_cnt; act0 = activity; mem_writes = 0; div_r = '0;
        burst_len_log.delete(); burst_log.delete();
        @(negedge clk);
        start = 1'b1; f_addr = fa; m_addr = ma; len_in = 17'(len);
        @(negedge clk);
        start = 1'b0;
        n_checks++;
        if (len == 0) begin
            if ({done, busy} !== 2'b10) begin
                n_fail++;
                $display("FAIL %s zero_len_done: got done=%0b busy=%0b required done=1 busy=0", tag, done, busy);
            end
        end else begin
            if ({done, busy} !== 2'b01) begin
                n_fail++;
                $display("FAIL %s busy_after_start: got done=%0b busy=%0b required done=0 busy=1", tag, done, busy);
            end
            cyc = 0;
            while (done !== 1'b1 && cyc < 20000) begin
                if (poke && cyc == 7) begin
                    start = 1'b1; f_addr = ~fa; m_addr = ~ma; len_in = 17'd1;
                end else start = 1'b0;
                @(negedge clk);
                cyc++;
            end
            start = 1'b0;
            n_checks++;
            if (done !== 1'b1) begin
                n_fail++;
                $display("FAIL %s timeout: no done after %0d cycles, required done", tag, cyc);
                rst = 1'b1; @(negedge clk); @(negedge clk); rst = 1'b0;
            end else if (busy !== 1'b0) begin
                n_fail++;
                $display("FAIL %s busy_at_done: got %0b required 0", tag, busy);
            end
        end
        repeat (3) @(negedge clk);
        n_checks++;
        if (done_cnt - done0 != 1 || busy !== 1'b0) begin
            n_fail++;
            $display("FAIL %s done_pulses: got %0d busy=%0b required 1 busy=0", tag, done_cnt - done0, busy);
        end
        n_checks++;
        if (mem_writes != len) begin
            n_fail++;
            $display("FAIL %s mem_write_count: got %0d required %0d", tag, mem_writes, len);
        end
        bad = 0;
        for (int i = 0; i < len; i++) begin
            eb = flash_byte(fa + 24'(i));
            n_checks++;
            if (mem[ma + 16'(i)] !== eb) begin
                n_fail++;
                if (bad < 4) $display("FAIL %s mem_data[%h]: got %h required %h", tag, ma + 16'(i), mem[ma + 16'(i)], eb);
                bad++;
            end
        end
        nb = (len + CHUNK - 1) / CHUNK;
        n_checks++;
        if (burst_len_log.size() != nb) begin
            n_fail++;
            $display("FAIL %s burst_count: got %0d required %0d", tag, burst_len_log.size(), nb);
        end else begin
            pos = 0;
            for (int k = 0; k < nb; k++) begin
                nk  = (len - k * CHUNK < CHUNK) ? len - k * CHUNK : CHUNK;
                ak  = fa + 24'(k * CHUNK);
                bad = (burst_len_log[k] != 4 + nk) ? 1 : 0;
                if (bad == 0) begin
                    if (burst_log[pos] != 8'h03 || burst_log[pos+1] != ak[23:16] ||
                        burst_log[pos+2] != ak[15:8] || burst_log[pos+3] != ak[7:0]) bad = 1;
                    for (int j = 4; j < 4 + nk; j++) if (burst_log[pos+j] != 8'h00) bad = 1;
                end
                n_checks++;
                if (bad != 0) begin
                    n_fail++;
                    $display("FAIL %s burst%0d: got len %0d hdr %h%h%h%h required len %0d hdr 03%h", tag, k,
                             burst_len_log[k], burst_log[pos], burst_log[pos+1], burst_log[pos+2],
                             burst_log[pos+3], 4 + nk, ak);
                end
                pos += burst_len_log[k];
            end
        end
        if (len > 0) begin
            n_checks++;
            if (div_r !== 16'(CLK_DIV)) begin
                n_fail++;
                $display("FAIL %s clkdiv: got %h required %h", tag, div_r, 16'(CLK_DIV));
            end
        end else begin
            n_checks++;
            if (activity != act0) begin
                n_fail++;
                $display("FAIL %s zero_len_activity: got %0d active cycles required 0", tag, activity - act0);
            end
        end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        repeat (3) @(negedge clk);
        n_checks++;
        if ({busy, done, hs_read, hs_write, hs_addr, hs_data, mem_we, mem_addr, mem_wdata} !== '0) begin
            n_fail++;
            $display("FAIL reset_outputs: got %b required all zero",
                     {busy, done, hs_read, hs_write, hs_addr, hs_data, mem_we, mem_addr, mem_wdata});
        end
        rst = 1'b0;
        repeat (2) @(negedge clk);
        n_checks++;
        if ({busy, done, hs_read, hs_write, mem_we} !== 5'b0) begin
            n_fail++;
            $display("FAIL idle_after_reset: got %b required 00000", {busy, done, hs_read, hs_write, mem_we});
        end
    endtask

    task automatic test_single_chunk();
        salt = 8'h00;
        run_copy(24'h001000, 16'h0100, 4, "T1", 0);
    endtask

    task automatic test_multi_chunk();
        salt = 8'($urandom);
        run_copy(24'h03_0F00, 16'h2000, 30, "T2", 0);
    endtask

    task automatic test_zero_len();
        run_copy(24'h00_5555, 16'h0300, 0, "T3", 0);
    endtask

    task automatic test_mem_stall();
        salt = 8'($urandom);
        mem_rand = 0; stall_cycles = 0; stall_at = 2;
        run_copy(24'h00_4000, 16'h0500, 8, "T4", 0);
        n_checks++;
        if (stall_cycles != 5) begin
            n_fail++;
            $display("FAIL T4 stall_cycles: got %0d required 5", stall_cycles);
        end
        mem_rand = 1; stall_at = -1;
    endtask

    task automatic test_wrap();
        salt = 8'h00;
        run_copy(24'hFFFFFE, 16'hFFFE, 4, "T5", 0);
    endtask

    task automatic test_abort();
        int cyc;
        salt = 8'($urandom);
        @(negedge clk);
        start = 1'b1; f_addr = 24'h12_3400; m_addr = 16'h4000; len_in = 17'd20;
        @(negedge clk);
        start = 1'b0;
        cyc = 0;
        while (mem_we !== 1'b1 && cyc < 5000) begin
            @(negedge clk);
            cyc++;
        end
        n_checks++;
        if (mem_we !== 1'b1) begin
            n_fail++;
            $display("FAIL T6 reach_pop: got mem_we=%0b required 1", mem_we);
        end
        rst = 1'b1;
        @(negedge clk);
        n_checks++;
        if ({busy, done, hs_read, hs_write, hs_addr, hs_data, mem_we, mem_addr, mem_wdata} !== '0) begin
            n_fail++;
            $display("FAIL T6 abort_outputs: got %b required all zero",
                     {busy, done, hs_read, hs_write, hs_addr, hs_data, mem_we, mem_addr, mem_wdata});
        end
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        run_copy(24'h12_3400, 16'h4000, 20, "T6_restart", 0);
    endtask

    task automatic test_back_to_back();
        for (int it = 0; it < 6; it++) begin
            salt = 8'($urandom);
            run_copy(24'($urandom), 16'($urandom), $urandom_range(1, 40), $sformatf("RND%0d", it), it[0]);
        end
    endtask

    initial begin
        test_reset();
        test_single_chunk();
        test_multi_chunk();
        test_zero_len();
        test_mem_stall();
        test_wrap();
        test_abort();
        test_back_to_back();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
